layer1_frame_sched: RTL and testbench

LAYER1_FRAME_SCHED -- requirements
Module: layer1_frame_sched

---
 rtl/layer1_frame_sched.sv | 200 ++++++++++++++++++++
 tb/tb_layer1_frame_sched.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer1_frame_sched.sv
// ---------------------------------------------------------------------------
// layer1_frame_sched
//
// Purpose:
//   Frame scheduler for the layer-1 modulation paths. Each input frame starts
//   with one header beat that carries a magic byte, a payload beat count and a
//   2-bit modulation mode. A valid frame's payload is passed straight through
//   with zero latency to the path chosen by the mode. Malformed frames are
//   discarded and counted. Frames that are too short or too long are
//   forwarded up to the point where they go wrong and are then counted as
//   errors.
//
// Ports:
//   clk                  clock
//   reset                asynchronous reset, active low
//   cfg_enable           allows a new header to be accepted
//   s_axis_input_*       AXI-Stream input (64-bit header/payload beats)
//   m_axis_path_tvalid   one valid per modulation path
//   m_axis_path_tready   one ready per modulation path
//   m_axis_path_tdata    payload bus shared by all paths
//   m_axis_path_tlast    end of forwarded frame
//   busy                 high while a frame is being forwarded or dropped
//   cur_mode             path of the current frame, or of the last one
//   stat_frames          count of good frames (saturating)
//   stat_errs            count of errored frames (saturating)
// ---------------------------------------------------------------------------
module layer1_frame_sched #(
    parameter int NPATH = 4,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_enable,
    input  logic             s_axis_input_tvalid,
    output logic             s_axis_input_tready,
    input  logic [63:0]      s_axis_input_tdata,
    input  logic             s_axis_input_tlast,
    output logic [NPATH-1:0] m_axis_path_tvalid,
    input  logic [NPATH-1:0] m_axis_path_tready,
    output logic [63:0]      m_axis_path_tdata,
    output logic             m_axis_path_tlast,
    output logic             busy,
    output logic [1:0]       cur_mode,
    output logic [15:0]      stat_frames,
    output logic [15:0]      stat_errs
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [7:0]       HDR_MAGIC = 8'hA5;
    localparam logic [LEN_W-1:0] LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ZERO  = {LEN_W{1'b0}};

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] remaining;

    logic [7:0]       hdr_magic;
    logic [LEN_W-1:0] hdr_len;
    logic [1:0]       hdr_mode;
    logic             rem_is_one;
    logic             sel_ready;
    logic             xfer;

    logic             load_hdr;
    logic             dec_rem;
    logic             inc_frames;
    logic             inc_errs;

    assign hdr_magic  = s_axis_input_tdata[63:56];
    assign hdr_len    = s_axis_input_tdata[LEN_W+15:16];
    assign hdr_mode   = s_axis_input_tdata[1:0];
    assign rem_is_one = (remaining == LEN_ONE);
    assign xfer       = s_axis_input_tvalid && s_axis_input_tready;

    // Ready of the path selected by cur_mode. A mode with no matching path
    // (only possible when NPATH < 4) reads as not ready, so it stalls rather
    // than indexing past the end of the vector.
    always_comb begin
        sel_ready = 1'b0;
        for (int i = 0; i < NPATH; i++) begin
            if (cur_mode == 2'(i)) begin
                sel_ready = m_axis_path_tready[i];
            end
        end
    end

    // State register together with the frame bookkeeping it controls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            remaining   <= LEN_ZERO;
            cur_mode    <= 2'd0;
            stat_frames <= 16'd0;
            stat_errs   <= 16'd0;
        end else begin
            state <= state_next;
            if (load_hdr) begin
                remaining <= hdr_len;
                cur_mode  <= hdr_mode;
            end else if (dec_rem) begin
                remaining <= remaining - LEN_ONE;
            end
            if (inc_frames && (stat_frames != 16'hFFFF)) begin
                stat_frames <= stat_frames + 16'd1;
            end
            if (inc_errs && (stat_errs != 16'hFFFF)) begin
                stat_errs <= stat_errs + 16'd1;
            end
        end
    end

    // Next-state decode. Header classification happens only on an accepted
    // beat in IDLE. In DATA the payload length and the input tlast are checked
    // against each other on every transfer.
    always_comb begin
        state_next = state;
        load_hdr   = 1'b0;
        dec_rem    = 1'b0;
        inc_frames = 1'b0;
        inc_errs   = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (s_axis_input_tlast) begin
                        // A header that is also the last beat has no payload
                        // to drop, so we stay in IDLE.
                        inc_errs = 1'b1;
                    end else if ((hdr_magic == HDR_MAGIC) && (hdr_len != LEN_ZERO)) begin
                        load_hdr   = 1'b1;
                        state_next = DATA;
                    end else begin
                        inc_errs   = 1'b1;
                        state_next = DROP;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    dec_rem = 1'b1;
                    if (s_axis_input_tlast) begin
                        if (rem_is_one) begin
                            inc_frames = 1'b1;
                        end else begin
                            inc_errs = 1'b1;
                        end
                        state_next = IDLE;
                    end else if (rem_is_one) begin
                        // Frame is longer than the header claimed. The extra
                        // beats are discarded up to the input tlast.
                        inc_errs   = 1'b1;
                        state_next = DROP;
                    end
                end
            end
            DROP: begin
                if (xfer && s_axis_input_tlast) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode. The payload is forwarded combinationally, so the input
    // handshake and the selected path's handshake complete on the same edge.
    always_comb begin
        s_axis_input_tready = 1'b0;
        m_axis_path_tvalid  = '0;
        m_axis_path_tdata   = 64'd0;
        m_axis_path_tlast   = 1'b0;
        busy                = (state != IDLE);
        case (state)
            IDLE: begin
                s_axis_input_tready = cfg_enable;
            end
            DATA: begin
                s_axis_input_tready = sel_ready;
                for (int i = 0; i < NPATH; i++) begin
                    m_axis_path_tvalid[i] = s_axis_input_tvalid && (cur_mode == 2'(i));
                end
                m_axis_path_tdata = s_axis_input_tdata;
                m_axis_path_tlast = rem_is_one || s_axis_input_tlast;
            end
            DROP: begin
                s_axis_input_tready = 1'b1;
            end
            default: begin
                s_axis_input_tready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_layer1_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_layer1_frame_sched
//
// Purpose:
//   Self-checking bench for layer1_frame_sched. The stimulus thread drives
//   directed frames and pushes every payload beat it expects to see forwarded
//   into a scoreboard queue. A separate monitor pops that queue on every
//   output handshake and compares path, data and tlast. The stimulus thread
//   also checks status outputs directly at chosen points.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_layer1_frame_sched;

    localparam int NPATH = 4;
    localparam int LEN_W = 16;

    logic             clk;
    logic             reset;
    logic             cfg_enable;
    logic             s_valid;
    logic             s_ready;
    logic [63:0]      s_data;
    logic             s_last;
    logic [NPATH-1:0] path_valid;
    logic [NPATH-1:0] path_ready;
    logic [63:0]      path_data;
    logic             path_last;
    logic             busy;
    logic [1:0]       cur_mode;
    logic [15:0]      stat_frames;
    logic [15:0]      stat_errs;

    typedef struct {
        logic [1:0]  path;
        logic [63:0] data;
        logic        last;
    } exp_beat_t;

    exp_beat_t exp_q[$];

    int checks;
    int errors;
    logic toggle_en;
    logic mirror_chk;

    layer1_frame_sched #(
        .NPATH(NPATH),
        .LEN_W(LEN_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .cfg_enable          (cfg_enable),
        .s_axis_input_tvalid (s_valid),
        .s_axis_input_tready (s_ready),
        .s_axis_input_tdata  (s_data),
        .s_axis_input_tlast  (s_last),
        .m_axis_path_tvalid  (path_valid),
        .m_axis_path_tready  (path_ready),
        .m_axis_path_tdata   (path_data),
        .m_axis_path_tlast   (path_last),
        .busy                (busy),
        .cur_mode            (cur_mode),
        .stat_frames         (stat_frames),
        .stat_errs           (stat_errs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Header layout: [63:56] magic, [31:16] beat count, [1:0] mode.
    function automatic logic [63:0] make_hdr(input logic [7:0] magic,
                                             input logic [15:0] n,
                                             input logic [1:0] mode);
        return {magic, 24'h0, n, 14'h0, mode};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic expectBeat(input logic [1:0] path, input logic [63:0] data,
                              input logic last);
        exp_beat_t e;
        e.path = path;
        e.data = data;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Entered and left just after a rising edge; holds the beat until the
    // DUT's input ready is seen at a falling edge.
    task automatic applyStimulus(input logic [63:0] data, input logic last);
        logic accepted;
        accepted = 1'b0;
        s_valid  = 1'b1;
        s_data   = data;
        s_last   = last;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (mirror_chk) begin
                checkOutput("tready_mirror", 64'(s_ready), 64'(path_ready[2]));
            end
            if (s_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: beat %h not accepted, expected acceptance", data);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 64'd0;
    endtask

    // Monitor: every output handshake must match the head of the scoreboard.
    initial begin
        exp_beat_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int p = 0; p < NPATH; p++) begin
                    if (path_valid[p] && path_ready[p]) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpected_beat: path %0d data %h, expected no beat", p, path_data);
                        end else begin
                            e = exp_q.pop_front();
                            checkOutput("beat_path", 64'(p), 64'(e.path));
                            checkOutput("beat_data", path_data, e.data);
                            checkOutput("beat_last", 64'(path_last), 64'(e.last));
                        end
                    end
                end
            end
        end
    end

    // Toggles path 2 ready every cycle while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) begin
                path_ready[2] = ~path_ready[2];
            end
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        toggle_en  = 1'b0;
        mirror_chk = 1'b0;
        reset      = 1'b0;
        cfg_enable = 1'b1;
        s_valid    = 1'b0;
        s_data     = 64'd0;
        s_last     = 1'b0;
        path_ready = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_frames", 64'(stat_frames), 64'd0);
        checkOutput("rst_errs", 64'(stat_errs), 64'd0);
        checkOutput("rst_mode", 64'(cur_mode), 64'd0);
        checkOutput("rst_valid", 64'(path_valid), 64'd0);
        checkOutput("rst_tlast", 64'(path_last), 64'd0);
        checkOutput("rst_tready", 64'(s_ready), 64'd1);

        // Good frame on path 2, always ready
        applyStimulus(make_hdr(8'hA5, 16'd3, 2'd2), 1'b0);
        checkOutput("t1_busy", 64'(busy), 64'd1);
        checkOutput("t1_mode", 64'(cur_mode), 64'd2);
        expectBeat(2'd2, 64'h1111_0000_0000_0001, 1'b0);
        expectBeat(2'd2, 64'h1111_0000_0000_0002, 1'b0);
        expectBeat(2'd2, 64'h1111_0000_0000_0003, 1'b1);
        applyStimulus(64'h1111_0000_0000_0001, 1'b0);
        applyStimulus(64'h1111_0000_0000_0002, 1'b0);
        applyStimulus(64'h1111_0000_0000_0003, 1'b1);
        checkOutput("t1_frames", 64'(stat_frames), 64'd1);
        checkOutput("t1_errs", 64'(stat_errs), 64'd0);
        checkOutput("t1_busy_end", 64'(busy), 64'd0);

        // Same frame with path 2 ready toggling
        applyStimulus(make_hdr(8'hA5, 16'd3, 2'd2), 1'b0);
        toggle_en  = 1'b1;
        mirror_chk = 1'b1;
        expectBeat(2'd2, 64'h2222_0000_0000_00A1, 1'b0);
        expectBeat(2'd2, 64'h2222_0000_0000_00A2, 1'b0);
        expectBeat(2'd2, 64'h2222_0000_0000_00A3, 1'b1);
        applyStimulus(64'h2222_0000_0000_00A1, 1'b0);
        applyStimulus(64'h2222_0000_0000_00A2, 1'b0);
        applyStimulus(64'h2222_0000_0000_00A3, 1'b1);
        mirror_chk = 1'b0;
        toggle_en  = 1'b0;
        path_ready = 4'hF;
        checkOutput("t2_frames", 64'(stat_frames), 64'd2);

        // Short frame: N=4, tlast on beat 2
        applyStimulus(make_hdr(8'hA5, 16'd4, 2'd1), 1'b0);
        expectBeat(2'd1, 64'h3333_0000_0000_0001, 1'b0);
        expectBeat(2'd1, 64'h3333_0000_0000_0002, 1'b1);
        applyStimulus(64'h3333_0000_0000_0001, 1'b0);
        applyStimulus(64'h3333_0000_0000_0002, 1'b1);
        checkOutput("t3_errs", 64'(stat_errs), 64'd1);
        checkOutput("t3_busy", 64'(busy), 64'd0);

        // Long frame: N=2, five payload beats; drop must not depend on path ready
        applyStimulus(make_hdr(8'hA5, 16'd2, 2'd0), 1'b0);
        expectBeat(2'd0, 64'h4444_0000_0000_0001, 1'b0);
        expectBeat(2'd0, 64'h4444_0000_0000_0002, 1'b1);
        applyStimulus(64'h4444_0000_0000_0001, 1'b0);
        applyStimulus(64'h4444_0000_0000_0002, 1'b0);
        checkOutput("t4_errs", 64'(stat_errs), 64'd2);
        checkOutput("t4_drop_busy", 64'(busy), 64'd1);
        path_ready = 4'b1110;
        for (int b = 3; b <= 5; b++) begin
            @(negedge clk);
            checkOutput("t4_drop_tready", 64'(s_ready), 64'd1);
            @(posedge clk);
            #1;
            applyStimulus(64'h4444_0000_0000_0000 | 64'(b), (b == 5));
        end
        path_ready = 4'hF;
        checkOutput("t4_busy_end", 64'(busy), 64'd0);
        checkOutput("t4_errs_end", 64'(stat_errs), 64'd2);

        // Bad magic: nothing forwarded
        applyStimulus(make_hdr(8'h5A, 16'd2, 2'd3), 1'b0);
        applyStimulus(64'h5555_0000_0000_0001, 1'b0);
        applyStimulus(64'h5555_0000_0000_0002, 1'b1);
        checkOutput("t5_errs", 64'(stat_errs), 64'd3);
        checkOutput("t5_busy", 64'(busy), 64'd0);

        // Zero-length header goes to DROP
        applyStimulus(make_hdr(8'hA5, 16'd0, 2'd1), 1'b0);
        checkOutput("t6_busy", 64'(busy), 64'd1);
        applyStimulus(64'h6666_0000_0000_0001, 1'b1);
        checkOutput("t6_errs", 64'(stat_errs), 64'd4);

        // Header with tlast: counted, stays idle
        applyStimulus(make_hdr(8'hA5, 16'd2, 2'd1), 1'b1);
        checkOutput("t7_errs", 64'(stat_errs), 64'd5);
        checkOutput("t7_busy", 64'(busy), 64'd0);

        // cfg_enable dropped mid-frame: frame still completes
        applyStimulus(make_hdr(8'hA5, 16'd1, 2'd3), 1'b0);
        cfg_enable = 1'b0;
        expectBeat(2'd3, 64'h7777_0000_0000_0001, 1'b1);
        applyStimulus(64'h7777_0000_0000_0001, 1'b1);
        checkOutput("t8_frames", 64'(stat_frames), 64'd3);
        s_valid = 1'b1;
        s_data  = make_hdr(8'hA5, 16'd1, 2'd0);
        @(negedge clk);
        checkOutput("t8_idle_tready", 64'(s_ready), 64'd0);
        checkOutput("t8_idle_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        s_valid    = 1'b0;
        s_data     = 64'd0;
        cfg_enable = 1'b1;

        // Reset mid-frame after one payload beat
        applyStimulus(make_hdr(8'hA5, 16'd3, 2'd2), 1'b0);
        expectBeat(2'd2, 64'h8888_0000_0000_0001, 1'b0);
        applyStimulus(64'h8888_0000_0000_0001, 1'b0);
        s_valid = 1'b1;
        s_data  = 64'h8888_0000_0000_0002;
        reset   = 1'b0;
        #2;
        checkOutput("t9_busy", 64'(busy), 64'd0);
        checkOutput("t9_valid", 64'(path_valid), 64'd0);
        checkOutput("t9_tdata", path_data, 64'd0);
        checkOutput("t9_tlast", 64'(path_last), 64'd0);
        checkOutput("t9_frames", 64'(stat_frames), 64'd0);
        checkOutput("t9_errs", 64'(stat_errs), 64'd0);
        checkOutput("t9_mode", 64'(cur_mode), 64'd0);
        s_valid = 1'b0;
        s_data  = 64'd0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(make_hdr(8'hA5, 16'd3, 2'd1), 1'b0);
        expectBeat(2'd1, 64'h9999_0000_0000_0001, 1'b0);
        expectBeat(2'd1, 64'h9999_0000_0000_0002, 1'b0);
        expectBeat(2'd1, 64'h9999_0000_0000_0003, 1'b1);
        applyStimulus(64'h9999_0000_0000_0001, 1'b0);
        applyStimulus(64'h9999_0000_0000_0002, 1'b0);
        applyStimulus(64'h9999_0000_0000_0003, 1'b1);
        checkOutput("t9_frames_after", 64'(stat_frames), 64'd1);
        checkOutput("t9_errs_after", 64'(stat_errs), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
